// File: rtl/dac_sweep_ctrl.sv
// DAC code sweep sequencer: one AD5300-format SPI frame per point, settle wait,
// then a valid/ack handshake with the measurement logic before stepping on.
module dac_sweep_ctrl #(
  parameter int CODE_WIDTH    = 8,
  parameter int FRAME_WIDTH   = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CODE_WIDTH-1:0]  start_code_i,
  input  logic [CODE_WIDTH-1:0]  stop_code_i,
  input  logic [CODE_WIDTH-1:0]  step_i,
  output logic [FRAME_WIDTH-1:0] spi_data_o,
  output logic                   spi_wre_o,
  input  logic                   spi_rdy_i,
  output logic                   pt_valid_o,
  output logic [CODE_WIDTH-1:0]  pt_code_o,
  input  logic                   meas_ack_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic [CODE_WIDTH:0]    pt_cnt_o
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_XFER, S_SETTLE, S_MEAS, S_NEXT} state_t;

  state_t                state, state_n;
  logic [CODE_WIDTH-1:0] code, stop_r, step_r, nxt_code;
  logic [CODE_WIDTH:0]   pt_cnt, nxt_wide;
  logic [SW-1:0]         settle_cnt;
  logic                  dir_dn, busy_seen, abort_flag, abort_eff;

  assign abort_eff  = abort_flag | abort_i;
  assign pt_code_o  = code;
  assign pt_cnt_o   = pt_cnt;

  always_comb begin
    spi_data_o = '0;
    spi_data_o[CODE_WIDTH+3:4] = code;
  end

  // Step in one extra bit so overflow/borrow is visible, then clamp to stop.
  always_comb begin
    if (dir_dn) nxt_wide = {1'b0, code} - {1'b0, step_r};
    else        nxt_wide = {1'b0, code} + {1'b0, step_r};
    nxt_code = nxt_wide[CODE_WIDTH-1:0];
    if (nxt_wide[CODE_WIDTH])
      nxt_code = stop_r;
    else if (dir_dn ? (nxt_wide[CODE_WIDTH-1:0] < stop_r) : (nxt_wide[CODE_WIDTH-1:0] > stop_r))
      nxt_code = stop_r;
  end

  always_comb begin
    state_n    = state;
    spi_wre_o  = 1'b0;
    pt_valid_o = 1'b0;
    done_o     = 1'b0;
    aborted_o  = 1'b0;
    busy_o     = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start_i) state_n = S_WRITE;
      S_WRITE: begin
        if (abort_eff) begin
          aborted_o = 1'b1;
          state_n   = S_IDLE;
        end else if (spi_rdy_i) begin
          spi_wre_o = 1'b1;
          state_n   = S_XFER;
        end
      end
      // Abort is only acted on once the frame has fully left the master.
      S_XFER: begin
        if (busy_seen && spi_rdy_i) begin
          if (abort_eff) begin
            aborted_o = 1'b1;
            state_n   = S_IDLE;
          end else if (SETTLE_CYCLES == 0) state_n = S_MEAS;
          else state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort_eff) begin
          aborted_o = 1'b1;
          state_n   = S_IDLE;
        end else if (settle_cnt == '0) state_n = S_MEAS;
      end
      S_MEAS: begin
        pt_valid_o = 1'b1;
        if (meas_ack_i) state_n = S_NEXT;
        else if (abort_eff) begin
          aborted_o = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_NEXT: begin
        if (abort_eff) begin
          aborted_o = 1'b1;
          state_n   = S_IDLE;
        end else if (code == stop_r) begin
          done_o  = 1'b1;
          state_n = S_IDLE;
        end else state_n = S_WRITE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      code       <= '0;
      stop_r     <= '0;
      step_r     <= '0;
      dir_dn     <= 1'b0;
      pt_cnt     <= '0;
      settle_cnt <= '0;
      busy_seen  <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE) abort_flag <= 1'b0;
      else if (abort_i)    abort_flag <= 1'b1;
      if (state == S_IDLE && start_i) begin
        code   <= start_code_i;
        stop_r <= stop_code_i;
        step_r <= (step_i == '0) ? CODE_WIDTH'(1) : step_i;
        dir_dn <= (start_code_i > stop_code_i);
        pt_cnt <= '0;
      end
      if (spi_wre_o) busy_seen <= 1'b0;
      else if (state == S_XFER && !spi_rdy_i) busy_seen <= 1'b1;
      if (state == S_XFER && state_n == S_SETTLE) settle_cnt <= SETTLE_LD;
      else if (state == S_SETTLE) settle_cnt <= settle_cnt - SW'(1);
      if (state == S_MEAS && meas_ack_i) pt_cnt <= pt_cnt + (CODE_WIDTH+1)'(1);
      if (state == S_NEXT && state_n == S_WRITE) code <= nxt_code;
    end
  end
endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Directed bench for dac_sweep_ctrl: two instances (settle 6 and settle 0),
// a behavioural SPI master and an auto-ack measurement responder.
module tb_dac_sweep_ctrl;
  localparam int XLEN = 4;
  localparam int SET0 = 6;

  logic clk = 0;
  always #5 clk = ~clk;

  logic       rst_n = 0;
  logic [1:0] start = 0, rdy = 2'b11, wre, valid, busy, done, abrt, ack;
  logic       abort = 0;
  logic [7:0] sc = 0, pc = 0, st = 0;
  logic [15:0] data [2];
  logic [7:0]  pcode [2];
  logic [8:0]  pcnt [2];

  dac_sweep_ctrl #(.CODE_WIDTH(8), .FRAME_WIDTH(16), .SETTLE_CYCLES(SET0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .abort_i(abort),
    .start_code_i(sc), .stop_code_i(pc), .step_i(st),
    .spi_data_o(data[0]), .spi_wre_o(wre[0]), .spi_rdy_i(rdy[0]),
    .pt_valid_o(valid[0]), .pt_code_o(pcode[0]), .meas_ack_i(ack[0]),
    .busy_o(busy[0]), .done_o(done[0]), .aborted_o(abrt[0]), .pt_cnt_o(pcnt[0]));

  dac_sweep_ctrl #(.CODE_WIDTH(8), .FRAME_WIDTH(16), .SETTLE_CYCLES(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .abort_i(abort),
    .start_code_i(sc), .stop_code_i(pc), .step_i(st),
    .spi_data_o(data[1]), .spi_wre_o(wre[1]), .spi_rdy_i(rdy[1]),
    .pt_valid_o(valid[1]), .pt_code_o(pcode[1]), .meas_ack_i(ack[1]),
    .busy_o(busy[1]), .done_o(done[1]), .aborted_o(abrt[1]), .pt_cnt_o(pcnt[1]));

  // SPI master model: rdy drops after a strobe and returns XLEN cycles later
  logic [1:0] hold = 0, wre_s = 0;
  int busy_c [2];
  always @(negedge clk) wre_s <= wre;
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        busy_c[i] <= 0;
        rdy[i]    <= !hold[i];
      end else begin
        rdy[i]    <= !hold[i] && !wre_s[i] && (busy_c[i] <= 1);
        busy_c[i] <= wre_s[i] ? XLEN : (busy_c[i] > 0 ? busy_c[i] - 1 : 0);
      end
    end

  int sel = 0, cyc = 0, n_wre = 0, n_val = 0, n_done = 0, n_abrt = 0, rise_cyc = 0, vcnt = 0;
  int n_cmp = 0, n_err = 0;
  logic pv = 0, pr = 1, auto_ack = 1, man_ack = 0, auto_p = 0;
  logic [15:0] frq [$];
  logic [7:0]  cq [$];
  int          latq [$];

  assign ack[0] = (sel == 0) && (auto_ack ? auto_p : man_ack);
  assign ack[1] = (sel == 1) && (auto_ack ? auto_p : man_ack);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vcnt   = valid[sel] ? vcnt + 1 : 0;
    auto_p = valid[sel] && (vcnt == 2);
    if (wre[sel]) begin
      frq.push_back(data[sel]);
      n_wre++;
    end
    if (rdy[sel] && !pr) rise_cyc = cyc;
    if (valid[sel] && !pv) begin
      cq.push_back(pcode[sel]);
      latq.push_back(cyc - rise_cyc);
      n_val++;
    end
    if (done[sel]) n_done++;
    if (abrt[sel]) n_abrt++;
    pv = valid[sel];
    pr = rdy[sel];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    frq.delete(); cq.delete(); latq.delete();
    n_wre = 0; n_val = 0; n_done = 0; n_abrt = 0;
  endtask

  task automatic wait_idle(input int s, input string nm);
    int k = 0;
    while (busy[s] && k < 3000) begin tick(); k++; end
    chk({nm, "_timeout"}, k < 3000, 1);
  endtask

  typedef struct packed {
    logic [31:0]      s;
    logic [7:0]       a, b, st;
    logic [31:0]      n;
    logic [3:0][7:0]  c;
    logic [3:0][15:0] f;
  } vec_t;

  task automatic run_sweep(input vec_t v, input string nm);
    int k = 0;
    int setl = (v.s == 0) ? SET0 : 0;
    clr_mon();
    sel = v.s; sc = v.a; pc = v.b; st = v.st;
    tick();
    start[v.s] = 1'b1;
    tick();
    start = '0;
    while (n_done == 0 && n_abrt == 0 && k < 3000) begin tick(); k++; end
    chk({nm, "_timeout"}, k < 3000, 1);
    repeat (4) tick();
    chk({nm, "_nframes"}, frq.size(), v.n);
    chk({nm, "_npoints"}, n_val, v.n);
    for (int j = 0; j < v.n && j < frq.size() && j < cq.size(); j++) begin
      chk($sformatf("%s_frame%0d", nm, j), frq[j], v.f[j]);
      chk($sformatf("%s_code%0d", nm, j), cq[j], v.c[j]);
      chk($sformatf("%s_lat%0d", nm, j), latq[j], setl + 1);
    end
    chk({nm, "_done"}, n_done, 1);
    chk({nm, "_aborted"}, n_abrt, 0);
    chk({nm, "_ptcnt"}, pcnt[v.s], v.n);
    chk({nm, "_busy"}, busy[v.s], 0);
  endtask

  vec_t vt [5];

  initial begin
    vt[0] = '{s:0, a:8'd10,  b:8'd20,  st:8'd5, n:3, c:{8'd0, 8'd20, 8'd15, 8'd10},
              f:{16'h0000, 16'h0140, 16'h00F0, 16'h00A0}};
    vt[1] = '{s:0, a:8'd250, b:8'd255, st:8'd4, n:3, c:{8'd0, 8'd255, 8'd254, 8'd250},
              f:{16'h0000, 16'h0FF0, 16'h0FE0, 16'h0FA0}};
    vt[2] = '{s:0, a:8'd3,   b:8'd0,   st:8'd2, n:3, c:{8'd0, 8'd0, 8'd1, 8'd3},
              f:{16'h0000, 16'h0000, 16'h0010, 16'h0030}};
    vt[3] = '{s:1, a:8'h80,  b:8'h80,  st:8'd0, n:1, c:{8'd0, 8'd0, 8'd0, 8'h80},
              f:{16'h0000, 16'h0000, 16'h0000, 16'h0800}};
    vt[4] = '{s:0, a:8'd0,   b:8'd7,   st:8'd3, n:4, c:{8'd7, 8'd6, 8'd3, 8'd0},
              f:{16'h0070, 16'h0060, 16'h0030, 16'h0000}};

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_valid%0d", i), valid[i], 0);
      chk($sformatf("rst_wre%0d", i), wre[i], 0);
      chk($sformatf("rst_data%0d", i), data[i], 0);
      chk($sformatf("rst_ptcnt%0d", i), pcnt[i], 0);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_sweep(vt[i], $sformatf("vec%0d", i));

    // rdy held low in WRITE, then abort while the frame is in flight
    begin
      int k = 0;
      clr_mon();
      sel = 0; sc = 8'd10; pc = 8'd20; st = 8'd5;
      hold[0] = 1'b1;
      repeat (2) tick();
      start[0] = 1'b1; tick(); start = '0;
      repeat (20) tick();
      chk("hold_nowre", n_wre, 0);
      chk("hold_busy", busy[0], 1);
      hold[0] = 1'b0;
      while (n_wre == 0 && k < 100) begin tick(); k++; end
      chk("hold_wre_timeout", k < 100, 1);
      tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("xfer_abort_waits", busy[0], 1);
      wait_idle(0, "xfer_abort");
      repeat (4) tick();
      chk("xfer_abort_pulse", n_abrt, 1);
      chk("xfer_abort_nodone", n_done, 0);
      chk("xfer_abort_wre", n_wre, 1);
      chk("xfer_abort_noval", n_val, 0);
    end

    // ack and abort in the same MEAS cycle
    begin
      int k = 0;
      clr_mon();
      auto_ack = 1'b0;
      start[0] = 1'b1; tick(); start = '0;
      while (n_val == 0 && k < 200) begin tick(); k++; end
      chk("ackab_val_timeout", k < 200, 1);
      tick();
      man_ack = 1'b1; abort = 1'b1; tick(); man_ack = 1'b0; abort = 1'b0;
      wait_idle(0, "ackab");
      repeat (3) tick();
      chk("ackab_ptcnt", pcnt[0], 1);
      chk("ackab_aborted", n_abrt, 1);
      chk("ackab_nodone", n_done, 0);
      chk("ackab_wre", n_wre, 1);
      auto_ack = 1'b1;
    end

    // reset while settling, then a full sweep afterwards
    begin
      int k = 0;
      clr_mon();
      start[0] = 1'b1; tick(); start = '0;
      while (n_wre == 0 && k < 100) begin tick(); k++; end
      chk("rstset_wre_timeout", k < 100, 1);
      repeat (8) tick();
      chk("rstset_in_settle", busy[0] && !valid[0] && rdy[0], 1);
      rst_n = 1'b0; tick();
      chk("rstset_busy", busy[0], 0);
      chk("rstset_valid", valid[0], 0);
      chk("rstset_data", data[0], 0);
      chk("rstset_code", pcode[0], 0);
      chk("rstset_ptcnt", pcnt[0], 0);
      chk("rstset_flags", {done[0], abrt[0], wre[0]}, 0);
      rst_n = 1'b1; tick();
      run_sweep(vt[0], "post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
